// File: rtl/dmux_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin demux scheduler.
package dmux_pkg;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned STAT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/dmux8_next_ch.sv
// Combinational search: first enabled channel at or after start, wrapping mod 8.
module dmux8_next_ch
  import dmux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   start,
  output logic [CH_W-1:0]   ch,
  output logic              found
);

  logic [CH_W-1:0] idx;

  always_comb begin
    ch    = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = start + CH_W'(i);
      if (!found && mask[idx]) begin
        found = 1'b1;
        ch    = idx;
      end
    end
  end

endmodule

// File: rtl/dmux8_rr_scheduler.sv
// 1:8 round-robin demux scheduler with per-channel dwell and one-entry output register.
// Optional per-channel drained-beat counters behind macro DMUX_SCHED_STATS_EN.
module dmux8_rr_scheduler
  import dmux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DWELL  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CH_W-1:0]   sel,
  input  logic [CH_W-1:0]   stat_sel,
  output logic [STAT_W-1:0] stat_cnt
);

  localparam logic [7:0] DWELL_C = 8'(DWELL);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ptr, eff, rot;
  logic              eff_found, rot_found;
  logic [7:0]        cnt, cnt_new;
  logic              full, accept, drain;
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   sel_q;

  dmux8_next_ch u_eff (
    .mask  (ch_mask),
    .start (ptr),
    .ch    (eff),
    .found (eff_found)
  );

  // Starting just past eff wraps back to eff itself when it is the only enabled channel.
  dmux8_next_ch u_rot (
    .mask  (ch_mask),
    .start (eff + CH_W'(1)),
    .ch    (rot),
    .found (rot_found)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (|ch_mask) state_nxt = RUN;
  end

  // eff_found closes the one-cycle window where state is still RUN after the mask clears.
  assign drain    = full && out_ready[sel_q];
  assign in_ready = (state == RUN) && eff_found && (!full || out_ready[sel_q]);
  assign accept   = in_valid && in_ready;
  assign cnt_new  = (eff != ptr) ? 8'd1 : cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      if (accept) begin
        full   <= 1'b1;
        data_q <= in_data;
        sel_q  <= eff;
        if (cnt_new == DWELL_C) begin
          ptr <= rot_found ? rot : eff;
          cnt <= '0;
        end else begin
          ptr <= eff;
          cnt <= cnt_new;
        end
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

  assign out_valid = full ? (NUM_CH'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign sel       = sel_q;

`ifdef DMUX_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
    end else if (drain && (stat_q[sel_q] != '1)) begin
      stat_q[sel_q] <= stat_q[sel_q] + STAT_W'(1);
    end
  end

  assign stat_cnt = stat_q[stat_sel];
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule
